// File: rtl/sim_run_controller_if.sv
// Request/status bundle between the simulation top level and the run sequencer.
// The controller takes the slave side; the DPI/top-level wrapper takes the master side.
interface sim_run_controller_if #(
  parameter int COUNT_WIDTH = 32
);
  logic                   finish_req;
  logic                   soft_reset_req;
  logic                   core_rst_n;
  logic                   aux_rst_n;
  logic                   run_active;
  logic [COUNT_WIDTH-1:0] cycle_count;
  logic                   finish_now;
  logic                   done;

  modport master (
    output finish_req, soft_reset_req,
    input  core_rst_n, aux_rst_n, run_active, cycle_count, finish_now, done
  );

  modport slave (
    input  finish_req, soft_reset_req,
    output core_rst_n, aux_rst_n, run_active, cycle_count, finish_now, done
  );
endinterface

// File: rtl/sim_run_controller.sv
// Run sequencer: staggered reset release, run-cycle counting, and a drained
// finish that ends in a single finish_now pulse. Every output is a register.
module sim_run_controller #(
  parameter int RESET_CYCLES = 20,
  parameter int AUX_DELAY    = 4,
  parameter int DRAIN_CYCLES = 8,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  sim_run_controller_if.slave   bus
);

  typedef enum logic [2:0] {HOLD, STAGGER, RUN, DRAIN, DONE} state_e;

  localparam int HOLD_MAX = (RESET_CYCLES > AUX_DELAY) ? RESET_CYCLES : AUX_DELAY;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam int DRAIN_W  = $clog2(DRAIN_CYCLES + 1);

  localparam logic [HOLD_W-1:0]  CORE_LAST  = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  AUX_LAST   = HOLD_W'(AUX_DELAY - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [DRAIN_W-1:0]     drain_q, drain_d;
  logic                   pending_q, pending_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d, count_inc;
  logic                   core_q, core_d;
  logic                   aux_q, aux_d;
  logic                   run_q, run_d;
  logic                   finish_q, finish_d;
  logic                   done_q, done_d;

  // Saturate rather than wrap so a very long run never reads as a short one.
  assign count_inc = (count_q == '1) ? count_q : count_q + COUNT_WIDTH'(1);

  always_comb begin
    // NOTE: every next-value signal takes its default before the case, so no branch leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    hold_d    = hold_q;
    drain_d   = drain_q;
    pending_d = pending_q;
    count_d   = count_q;
    core_d    = core_q;
    aux_d     = aux_q;
    finish_d  = 1'b0;
    done_d    = done_q;

    case (state_q)
      HOLD: begin
        pending_d = pending_q | bus.finish_req;
        hold_d    = hold_q + HOLD_W'(1);
        if (hold_q == CORE_LAST) begin
          core_d = 1'b1;
          hold_d = '0;
          if (AUX_DELAY == 0) begin
            aux_d   = 1'b1;
            state_d = RUN;
          end else begin
            state_d = STAGGER;
          end
        end
      end

      STAGGER: begin
        pending_d = pending_q | bus.finish_req;
        hold_d    = hold_q + HOLD_W'(1);
        if (hold_q == AUX_LAST) begin
          aux_d   = 1'b1;
          hold_d  = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        count_d = count_inc;
        if (bus.soft_reset_req) begin
          // A finish arriving with the soft reset is remembered, not dropped.
          state_d   = HOLD;
          core_d    = 1'b0;
          aux_d     = 1'b0;
          count_d   = '0;
          hold_d    = '0;
          pending_d = pending_q | bus.finish_req;
        end else if (bus.finish_req || pending_q) begin
          state_d   = DRAIN;
          drain_d   = '0;
          pending_d = 1'b0;
        end
      end

      DRAIN: begin
        count_d = count_inc;
        drain_d = drain_q + DRAIN_W'(1);
        if (drain_q == DRAIN_LAST) begin
          finish_d = 1'b1;
          done_d   = 1'b1;
          state_d  = DONE;
        end
      end

      DONE: begin
        state_d = DONE;
      end

      default: state_d = HOLD;
    endcase

    run_d = (state_d == RUN) || (state_d == DRAIN);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= HOLD;
      hold_q    <= '0;
      drain_q   <= '0;
      pending_q <= 1'b0;
      count_q   <= '0;
      core_q    <= 1'b0;
      aux_q     <= 1'b0;
      run_q     <= 1'b0;
      finish_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the same pre-edge values.
      state_q   <= state_d;
      hold_q    <= hold_d;
      drain_q   <= drain_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      core_q    <= core_d;
      aux_q     <= aux_d;
      run_q     <= run_d;
      finish_q  <= finish_d;
      done_q    <= done_d;
    end
  end

  assign bus.core_rst_n  = core_q;
  assign bus.aux_rst_n   = aux_q;
  assign bus.run_active  = run_q;
  assign bus.cycle_count = count_q;
  assign bus.finish_now  = finish_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_sim_run_controller.sv
// Scoreboard bench for sim_run_controller: an edge-number timing model predicts
// every output per cycle; a monitor pops and compares after each clock edge.
module tb_sim_run_controller;

  localparam int A_RC = 20, A_AD = 4, A_DC = 8, A_W = 32;
  localparam int B_RC = 2,  B_AD = 0, B_DC = 3, B_W = 4;
  localparam longint A_MAX = 64'hFFFF_FFFF;
  localparam longint B_MAX = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sim_run_controller_if #(.COUNT_WIDTH(A_W)) bus_a ();
  sim_run_controller_if #(.COUNT_WIDTH(B_W)) bus_b ();

  sim_run_controller #(.RESET_CYCLES(A_RC), .AUX_DELAY(A_AD), .DRAIN_CYCLES(A_DC),
                       .COUNT_WIDTH(A_W))
    dut_a (.CLK(clk), .RST_N(rst_n), .bus(bus_a));

  sim_run_controller #(.RESET_CYCLES(B_RC), .AUX_DELAY(B_AD), .DRAIN_CYCLES(B_DC),
                       .COUNT_WIDTH(B_W))
    dut_b (.CLK(clk), .RST_N(rst_n), .bus(bus_b));

  // Model state in terms of absolute edge numbers since RST_N release.
  typedef struct {
    int n;
    int core_rel;
    int aux_rel;
    int fin_edge;
    bit pending;
  } model_t;

  typedef struct {
    int     edge_n;
    bit     core;
    bit     aux;
    bit     run;
    bit     fin;
    bit     done;
    longint cnt;
  } exp_t;

  exp_t   qa[$];
  exp_t   qb[$];
  model_t ma, mb;
  exp_t   ea, eb;
  int     errors = 0;
  int     checks = 0;
  int     last_fin_a = -1;
  int     last_fin_b = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic model_t model_init(input int rc, input int ad);
    model_t m;
    m.n        = 0;
    m.core_rel = rc;
    m.aux_rel  = rc + ad;
    m.fin_edge = -1;
    m.pending  = 1'b0;
    return m;
  endfunction

  function automatic exp_t model_step(inout model_t m, input bit fr, input bit sr,
                                      input int rc, input int ad, input int dc,
                                      input longint cmax);
    exp_t   e;
    int     last;
    longint c;
    m.n++;
    if (m.n <= m.aux_rel) begin
      if (fr) m.pending = 1'b1;
    end else if (m.fin_edge < 0) begin
      if (sr) begin
        m.core_rel = m.n + rc;
        m.aux_rel  = m.n + rc + ad;
        m.pending  = m.pending | fr;
      end else if (fr || m.pending) begin
        m.fin_edge = m.n + dc;
        m.pending  = 1'b0;
      end
    end
    e.edge_n = m.n;
    e.done   = (m.fin_edge >= 0) && (m.n >= m.fin_edge);
    e.fin    = (m.n == m.fin_edge);
    e.core   = (m.n >= m.core_rel);
    e.aux    = (m.n >= m.aux_rel);
    e.run    = e.aux && !e.done;
    last     = e.done ? m.fin_edge : m.n;
    c        = e.aux ? longint'(last - m.aux_rel) : 0;
    e.cnt    = (c > cmax) ? cmax : c;
    return e;
  endfunction

  // Monitor: one comparison per DUT per edge while expectations are queued.
  always @(posedge clk) begin
    #1;
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      check($sformatf("a_out@%0d", ea.edge_n),
            {27'd0, bus_a.core_rst_n, bus_a.aux_rst_n, bus_a.run_active,
             bus_a.finish_now, bus_a.done, bus_a.cycle_count},
            {27'd0, ea.core, ea.aux, ea.run, ea.fin, ea.done, ea.cnt[31:0]});
      if (bus_a.finish_now) last_fin_a = ea.edge_n;
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      check($sformatf("b_out@%0d", eb.edge_n),
            {55'd0, bus_b.core_rst_n, bus_b.aux_rst_n, bus_b.run_active,
             bus_b.finish_now, bus_b.done, bus_b.cycle_count},
            {55'd0, eb.core, eb.aux, eb.run, eb.fin, eb.done, eb.cnt[3:0]});
      if (bus_b.finish_now) last_fin_b = eb.edge_n;
    end
  end

  task automatic drive_idle();
    bus_a.finish_req     = 1'b0;
    bus_a.soft_reset_req = 1'b0;
    bus_b.finish_req     = 1'b0;
    bus_b.soft_reset_req = 1'b0;
  endtask

  // Release RST_N and run ncyc edges; directed request edges (-1 = none) plus random requests.
  task automatic do_run(input int ncyc, input int fa, input int sa, input int fb,
                        input int pf, input int ps);
    bit fra, sra, frb, srb;
    @(negedge clk);
    rst_n      = 1'b1;
    ma         = model_init(A_RC, A_AD);
    mb         = model_init(B_RC, B_AD);
    last_fin_a = -1;
    last_fin_b = -1;
    for (int i = 0; i < ncyc; i++) begin
      fra = (ma.n + 1 == fa) || ($urandom_range(0, 99) < pf);
      sra = (ma.n + 1 == sa) || ($urandom_range(0, 99) < ps);
      frb = (mb.n + 1 == fb) || ($urandom_range(0, 99) < pf);
      srb = ($urandom_range(0, 99) < ps);
      bus_a.finish_req     = fra;
      bus_a.soft_reset_req = sra;
      bus_b.finish_req     = frb;
      bus_b.soft_reset_req = srb;
      qa.push_back(model_step(ma, fra, sra, A_RC, A_AD, A_DC, A_MAX));
      qb.push_back(model_step(mb, frb, srb, B_RC, B_AD, B_DC, B_MAX));
      @(negedge clk);
    end
    drive_idle();
  endtask

  // Assert RST_N between clock edges and confirm outputs clear without a clock.
  task automatic apply_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, "_async_a"},
          {27'd0, bus_a.core_rst_n, bus_a.aux_rst_n, bus_a.run_active,
           bus_a.finish_now, bus_a.done, bus_a.cycle_count}, 64'd0);
    check({tag, "_async_b"},
          {55'd0, bus_b.core_rst_n, bus_b.aux_rst_n, bus_b.run_active,
           bus_b.finish_now, bus_b.done, bus_b.cycle_count}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_held_a"},
          {27'd0, bus_a.core_rst_n, bus_a.aux_rst_n, bus_a.run_active,
           bus_a.finish_now, bus_a.done, bus_a.cycle_count}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive_idle();
    #3;
    check("por_a", {27'd0, bus_a.core_rst_n, bus_a.aux_rst_n, bus_a.run_active,
                    bus_a.finish_now, bus_a.done, bus_a.cycle_count}, 64'd0);
    check("por_b", {55'd0, bus_b.core_rst_n, bus_b.aux_rst_n, bus_b.run_active,
                    bus_b.finish_now, bus_b.done, bus_b.cycle_count}, 64'd0);
    repeat (2) @(negedge clk);

    // Power-on sequence and finish in RUN; dut_b saturates at 15 before finishing.
    do_run(60, 40, -1, 30, 0, 0);
    check("run1_finish_edge", last_fin_a, 48);
    check("run1_count_frozen", bus_a.cycle_count, 24);
    check("run1_done_sticky", bus_a.done, 1);
    check("b_finish_edge", last_fin_b, 33);
    check("b_count_saturated", bus_b.cycle_count, 15);
    apply_reset("r1");

    // Finish requested while still in HOLD.
    do_run(40, 5, -1, -1, 0, 0);
    check("early_finish_edge", last_fin_a, 33);
    apply_reset("r2");

    // Soft reset and finish on the same edge.
    do_run(90, 50, 50, -1, 0, 0);
    check("simul_finish_edge", last_fin_a, 83);
    apply_reset("r3");

    // Reset asserted mid-DRAIN: finish_now must never appear.
    do_run(33, 30, -1, -1, 0, 0);
    apply_reset("r4");
    check("no_finish_after_reset", last_fin_a, -1);

    // Random requests in every phase.
    for (int r = 0; r < 6; r++) begin
      do_run(150, -1, -1, -1, 3, 2);
      apply_reset($sformatf("rnd%0d", r));
    end

    #20;
    check("queues_drained", qa.size() + qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
